lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
Load/store unit: the initiator side of the data-memory port. It accepts one load or store per request from the execute stage, drives byte-address, write data, write strobe and LenSel into data memory, and returns load data with byte/half extraction and sign or zero extension. Data-memory reads are combinational; writes commit at posedge clk. The block sits between the EX/MEM pipeline register and data memory.

Parameters:
ADDR_W, 32, byte-address width
DATA_W, 32, data width; only 32 is supported
LEN_W, 2, LenSel width; 00=byte, 01=half, 11=word, 10 unused

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid: illegal funct3, or misaligned access without the feature
mem_addr  out  ADDR_W  byte address to data memory
mem_wdata  out  DATA_W  write data to data memory
mem_we  out  1  write strobe (MemRW)
mem_lensel  out  LEN_W  store length
mem_rdata  in  DATA_W  combinational read; bytes at addr+3..addr

Behaviour:
- Reset (rst_n low at posedge) forces:
  - state IDLE
  - req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0
  - mem_we=0, mem_addr=0, mem_wdata=0, mem_lensel=00
- Reset mid-operation aborts the access: no further mem_we pulse and no response.
- States: IDLE, ACCESS, SEQ (feature only), RESP.
- IDLE:
  - A request is accepted when req_valid & req_ready. It registers we, funct3, addr and wdata, then goes to ACCESS.
- Classification at accept:
  - illegal = load with funct3 in {011,110,111}, or store with funct3 > 010
  - misaligned = half with addr[0]=1, or word with addr[1:0]!=00
- ACCESS (exactly one cycle):
  - Drives mem_addr=addr, mem_wdata=wdata, and mem_lensel from funct3[1:0] (00→00, 01→01, 10→11).
  - mem_we = we & ~illegal & ~misaligned.
  - For loads, resp_rdata is captured at the end of the cycle:
    - byte: mem_rdata[7:0]
    - half: mem_rdata[15:0]
    - word: mem_rdata[31:0]
    - extension: sign for 000/001, zero for 100/101
  - Next state is RESP. With the feature enabled, a legal misaligned access goes to SEQ instead.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
  - resp_err is valid with it.
  - resp_rdata=0 when we=1 or resp_err=1.
- Latency: accept at cycle N, memory cycle at N+1, resp_valid at N+2. Next accept is no earlier than N+3.
- Outside ACCESS/SEQ: mem_we=0; mem_addr, mem_wdata and mem_lensel hold their last values.
- req_valid while busy is ignored; the requester must hold it until it sees req_ready.
- Address arithmetic is modulo 2^ADDR_W; 0xFFFFFFFF+1 wraps to 0.

Optional Feature:
LSU_MISALIGN_SPLIT_EN
- Defined:
  - A legal misaligned half/word is performed as 2/4 byte accesses in SEQ.
  - Byte counter k starts at 0. Each cycle drives mem_addr=addr+k, mem_lensel=00, mem_wdata[7:0]=wdata byte k, mem_we=we.
  - For loads, mem_rdata[7:0] is shifted into byte k of an assembly register.
  - After the last byte, go to RESP with extension applied; resp_err=0.
  - Latency: accept N, bytes at N+1..N+n, response at N+n+1.
  - The ACCESS cycle is replaced by SEQ; no full-width access is issued.
- Undefined: misaligned gives resp_err=1, no mem_we pulse, response at N+2.

Decomposition:
- lsu_pkg holds:
  - funct3 constants
  - LenSel encodings (LEN_B, LEN_H, LEN_W)
  - state enum
  - helper function: funct3 → lensel
- Sub-module lsu_load_align: combinational lane select plus sign/zero extension. It is shared by the ACCESS and SEQ paths.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-ACCESS of SW → no mem_we pulse after reset, resp_valid=0, req_ready=1.
- SW 0xDEADBEEF at 0x10 → mem_we=1 for one cycle, lensel=11, resp at N+2. Then LW 0x10 → resp_rdata=0xDEADBEEF, err=0.
- Memory bytes 0x80 0x7F at 0x20/0x21:
  - LB 0x20 → 0xFFFFFF80
  - LBU 0x20 → 0x00000080
  - LH 0x20 → 0x00007F80
- Illegal funct3 011 on a load, and 011 on a store → resp_err=1, rdata=0, mem_we never asserted.
- LW at 0x13:
  - feature off → resp_err=1 at N+2
  - feature on → 4 byte reads at 0x13..0x16, correct word, resp at N+5
- Back-to-back requests with req_valid held high → second accept exactly 3 cycles after the first; no request is lost or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, LenSel encodings,
// controller states and the funct3-to-LenSel mapping.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SEQ,
    ST_RESP
  } state_e;

  function automatic logic [1:0] f3_to_lensel(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return LEN_B;
      2'b01:   return LEN_H;
      default: return LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load lane select plus sign/zero extension; purely combinational.
// funct3[2] set selects zero extension (LBU/LHU).
module lsu_load_align (
  input  logic [31:0] data_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic sx;

  always_comb begin
    sx = ~funct3_i[2];
    case (funct3_i[1:0])
      2'b00:   data_o = {{24{sx & data_i[7]}}, data_i[7:0]};
      2'b01:   data_o = {{16{sx & data_i[15]}}, data_i[15:0]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one request per 3 cycles, memory access one cycle after accept.
// Optional LSU_MISALIGN_SPLIT_EN splits legal misaligned half/word into byte accesses.
module lsu_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [LEN_W-1:0]  mem_lensel,
  input  logic [DATA_W-1:0] mem_rdata
);
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q, mem_addr_q;
  logic [DATA_W-1:0] wdata_q, mem_wdata_q, rdata_q, asm_q, asm_d;
  logic [LEN_W-1:0]  mem_lensel_q;
  logic [1:0]        k_q;

  logic              accept, illegal_c, misal_c, last_byte;
  logic [DATA_W-1:0] align_in, align_out;

  assign accept    = req_valid & (state_q == ST_IDLE);
  assign illegal_c = req_we ? (req_funct3 > 3'b010)
                            : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
  assign misal_c   = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                     (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign last_byte = (f3_q[1:0] == 2'b01) ? (k_q == 2'd1) : (k_q == 2'd3);

  // The split path assembles bytes into asm_d before extension so both paths share one aligner.
  assign align_in  = (state_q == ST_SEQ) ? asm_d : mem_rdata;

  lsu_load_align u_align (
    .data_i   (align_in),
    .funct3_i (f3_q),
    .data_o   (align_out)
  );

  always_comb begin
    state_d    = state_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    mem_lensel = mem_lensel_q;
    mem_we     = 1'b0;
    asm_d      = asm_q;
    asm_d[8*k_q +: 8] = mem_rdata[7:0];
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = (SPLIT_EN && misal_c && !illegal_c) ? ST_SEQ : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        mem_lensel = LEN_W'(f3_to_lensel(f3_q));
        mem_we     = we_q & ~err_q;
        state_d    = ST_RESP;
      end
      ST_SEQ: begin
        mem_addr   = addr_q + ADDR_W'(k_q);
        mem_wdata  = {{(DATA_W-8){1'b0}}, wdata_q[8*k_q +: 8]};
        mem_lensel = LEN_W'(LEN_B);
        mem_we     = we_q;
        if (last_byte) state_d = ST_RESP;
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset arriving mid-access must not let the pending write through.
    mem_we = mem_we & rst_n;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      asm_q        <= '0;
      k_q          <= 2'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_lensel_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr;
      mem_wdata_q  <= mem_wdata;
      mem_lensel_q <= mem_lensel;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= illegal_c | (misal_c & ~SPLIT_EN);
        k_q     <= 2'd0;
        asm_q   <= '0;
      end
      if (state_q == ST_ACCESS) begin
        rdata_q <= (we_q | err_q) ? '0 : align_out;
      end
      if (state_q == ST_SEQ) begin
        k_q   <= k_q + 2'd1;
        asm_q <= asm_d;
        if (last_byte) rdata_q <= we_q ? '0 : align_out;
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;

endmodule
